l2_arbiter: RTL and testbench

Two-port request arbiter between the split L1 caches and the unified L2. It accepts 256-bit line requests from the instruction cache (read-only) and the data cache (read/write) and forwards exactly one at a time to the L2 CPU-side port. It returns the L2 response to the requester that owns the grant. Arbitration is round-robin by default, with a parameter for fixed data-cache priority.

---
 rtl/l2_arbiter_if.sv | 46 ++++
 rtl/l2_arbiter.sv | 112 +++++++++++
 tb/tb_l2_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// Bundle of L1-to-L2 request/response signals seen by the arbiter.
// The master modport is the arbiter's view.
// The slave modport is the view of the caches plus the L2 around it.
interface l2_arbiter_if #(
    parameter int s_line = 256
);
    // Instruction cache side (read-only)
    logic [31:0]       i_mem_address;
    logic              i_mem_read;
    logic [s_line-1:0] i_mem_rdata256;
    logic              i_mem_resp;

    // Data cache side (read / write-back)
    logic [31:0]       d_mem_address;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [s_line-1:0] d_mem_wdata256;
    logic [s_line-1:0] d_mem_rdata256;
    logic              d_mem_resp;

    // L2 CPU-side port
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [s_line-1:0] mem_wdata256;
    logic [s_line-1:0] mem_rdata256;
    logic              mem_resp;

    modport master (
        input  i_mem_address, i_mem_read,
        output i_mem_rdata256, i_mem_resp,
        input  d_mem_address, d_mem_read, d_mem_write, d_mem_wdata256,
        output d_mem_rdata256, d_mem_resp,
        output mem_address, mem_read, mem_write, mem_wdata256,
        input  mem_rdata256, mem_resp
    );

    modport slave (
        output i_mem_address, i_mem_read,
        input  i_mem_rdata256, i_mem_resp,
        output d_mem_address, d_mem_read, d_mem_write, d_mem_wdata256,
        input  d_mem_rdata256, d_mem_resp,
        input  mem_address, mem_read, mem_write, mem_wdata256,
        output mem_rdata256, mem_resp
    );
endinterface

// File: rtl/l2_arbiter.sv
// Two-port arbiter between the split L1 caches and the unified L2.
// One request is forwarded at a time; the L2 response goes back only to
// the port holding the grant. Ties are round-robin, or always won by the
// data cache when DCACHE_PRIORITY is 1. All L2-side outputs are decoded
// from the registered state, so an asynchronous reset drops them at once.
module l2_arbiter #(
    parameter int DCACHE_PRIORITY = 0,
    parameter int s_line          = 256
) (
    input  logic          clk,
    input  logic          rst,
    l2_arbiter_if.master  io_bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [s_line-1:0] ZERO_LINE = '0;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last_grant;      // 0 = I, 1 = D
    logic       w_last_grant_next;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_d;

    assign w_i_pend = io_bus.i_mem_read;
    assign w_d_pend = io_bus.d_mem_read | io_bus.d_mem_write;

    // Tie resolution: fixed D priority, or the side not granted last time.
    always_comb begin
        w_grant_d = 1'b0;
        if (w_i_pend && w_d_pend) begin
            if (DCACHE_PRIORITY != 0) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_d = ~r_last_grant;
            end
        end else begin
            w_grant_d = w_d_pend;
        end
    end

    // Next-state decode; a grant is held until the L2 answers.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_i_pend || w_d_pend) begin
                    w_state_next      = w_grant_d ? ST_SERVE_D : ST_SERVE_I;
                    w_last_grant_next = w_grant_d;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (io_bus.mem_resp) begin
                    w_state_next = ST_RELEASE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and grant history; reset makes the first tie go to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // L2-side request mux; IDLE and RELEASE drive everything to zero.
    always_comb begin
        io_bus.mem_address  = 32'h0;
        io_bus.mem_read     = 1'b0;
        io_bus.mem_write    = 1'b0;
        io_bus.mem_wdata256 = ZERO_LINE;
        case (r_state)
            ST_SERVE_I: begin
                io_bus.mem_address = io_bus.i_mem_address;
                io_bus.mem_read    = 1'b1;
            end
            ST_SERVE_D: begin
                io_bus.mem_address  = io_bus.d_mem_address;
                io_bus.mem_wdata256 = io_bus.d_mem_wdata256;
                io_bus.mem_write    = io_bus.d_mem_write;
                io_bus.mem_read     = io_bus.d_mem_read & ~io_bus.d_mem_write;
            end
            default: begin
            end
        endcase
    end

    // Response routing: only the granted port ever sees mem_resp.
    always_comb begin
        io_bus.i_mem_resp = (r_state == ST_SERVE_I) & io_bus.mem_resp;
        io_bus.d_mem_resp = (r_state == ST_SERVE_D) & io_bus.mem_resp;
    end

    // Read data is shared; it is qualified by the per-port resp.
    assign io_bus.i_mem_rdata256 = io_bus.mem_rdata256;
    assign io_bus.d_mem_rdata256 = io_bus.mem_rdata256;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: one round-robin and one D-priority instance share
// stimulus; the outputs of the instance under test are checked every cycle
// against a transaction-level model of grant ownership.
module tb_l2_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_arbiter_if #(.s_line(256)) bus0 ();
    l2_arbiter_if #(.s_line(256)) bus1 ();

    l2_arbiter #(.DCACHE_PRIORITY(0), .s_line(256)) dut0 (.clk(clk), .rst(rst), .io_bus(bus0));
    l2_arbiter #(.DCACHE_PRIORITY(1), .s_line(256)) dut1 (.clk(clk), .rst(rst), .io_bus(bus1));

    // Shared stimulus
    logic [31:0]  i_addr = '0;
    logic         i_read = 1'b0;
    logic [31:0]  d_addr = '0;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [255:0] d_wdata = '0;
    logic [255:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;

    assign bus0.i_mem_address = i_addr;   assign bus1.i_mem_address = i_addr;
    assign bus0.i_mem_read    = i_read;   assign bus1.i_mem_read    = i_read;
    assign bus0.d_mem_address = d_addr;   assign bus1.d_mem_address = d_addr;
    assign bus0.d_mem_read    = d_read;   assign bus1.d_mem_read    = d_read;
    assign bus0.d_mem_write   = d_write;  assign bus1.d_mem_write   = d_write;
    assign bus0.d_mem_wdata256 = d_wdata; assign bus1.d_mem_wdata256 = d_wdata;
    assign bus0.mem_rdata256  = l2_rdata; assign bus1.mem_rdata256  = l2_rdata;
    assign bus0.mem_resp      = l2_resp;  assign bus1.mem_resp      = l2_resp;

    // Instance under test: 0 = round-robin, 1 = D priority
    bit sel = 1'b0;
    logic [31:0]  o_addr;
    logic         o_rd, o_wr, o_iresp, o_dresp;
    logic [255:0] o_wdata, o_irdata, o_drdata;
    assign o_addr   = sel ? bus1.mem_address    : bus0.mem_address;
    assign o_rd     = sel ? bus1.mem_read       : bus0.mem_read;
    assign o_wr     = sel ? bus1.mem_write      : bus0.mem_write;
    assign o_wdata  = sel ? bus1.mem_wdata256   : bus0.mem_wdata256;
    assign o_iresp  = sel ? bus1.i_mem_resp     : bus0.i_mem_resp;
    assign o_dresp  = sel ? bus1.d_mem_resp     : bus0.d_mem_resp;
    assign o_irdata = sel ? bus1.i_mem_rdata256 : bus0.i_mem_rdata256;
    assign o_drdata = sel ? bus1.d_mem_rdata256 : bus0.d_mem_rdata256;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: who owns the L2 port in the coming cycle
    localparam int M_IDLE = 0, M_I = 1, M_D = 2, M_REL = 3;
    int  m_owner = M_IDLE;
    bit  m_last  = 1'b1;
    int  lat     = 0;
    int  fixed_lat = -1;
    bit  rand_req  = 1'b0;
    bit  keep_busy = 1'b0;
    bit  ab_data   = 1'b0;
    bit  grants[$];
    int  i_resp_cnt = 0;
    int  d_resp_cnt = 0;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic new_d_req();
        int kind;
        kind    = $urandom_range(0, 2);
        d_read  = (kind != 1);
        d_write = (kind != 0);
        d_addr  = $urandom() & 32'hFFFF_FFE0;
        d_wdata = rand_line();
    endtask

    // One clock: model reacts to what the DUT sampled, new stimulus is
    // driven, then the outputs are compared mid-cycle.
    task automatic step();
        bit pi, pd, pr, to_d;
        pi = i_read;
        pd = d_read | d_write;
        pr = l2_resp;
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
        case (m_owner)
            M_IDLE: if (pi || pd) begin
                if (pi && pd) to_d = sel ? 1'b1 : ~m_last;
                else          to_d = pd;
                m_owner = to_d ? M_D : M_I;
                m_last  = to_d;
                lat     = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
                grants.push_back(to_d);
            end
            M_I: if (pr) begin
                m_owner = M_REL;
                i_read  = 1'b0;
                if (keep_busy) i_read = 1'b1;
            end
            M_D: if (pr) begin
                m_owner = M_REL;
                d_read  = 1'b0;
                d_write = 1'b0;
                if (keep_busy) d_write = 1'b1;
            end
            default: m_owner = M_IDLE;
        endcase
        if (rand_req) begin
            if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_addr = $urandom() & 32'hFFFF_FFE0;
            end
            if (!(d_read || d_write) && $urandom_range(0, 2) == 0) new_d_req();
        end
        // L2 behaviour: answer the forwarded request after lat cycles
        if (m_owner == M_I || m_owner == M_D) begin
            if (lat == 0) begin
                l2_resp  = 1'b1;
                l2_rdata = ab_data ? {32{8'hAB}} : rand_line();
            end else begin
                lat--;
            end
        end else if (rand_req && $urandom_range(0, 5) == 0) begin
            l2_resp  = 1'b1;            // stray pulse, must be ignored
            l2_rdata = rand_line();
        end
        @(negedge clk);
        check_val("mem_read",  o_rd,
                  m_owner == M_I ? 1'b1 : (m_owner == M_D ? (d_read & ~d_write) : 1'b0));
        check_val("mem_write", o_wr, m_owner == M_D ? d_write : 1'b0);
        check_val("mem_address", o_addr,
                  m_owner == M_I ? i_addr : (m_owner == M_D ? d_addr : 32'h0));
        check_val("mem_wdata", o_wdata, m_owner == M_D ? d_wdata : 256'h0);
        check_val("i_mem_resp", o_iresp, (m_owner == M_I) && l2_resp);
        check_val("d_mem_resp", o_dresp, (m_owner == M_D) && l2_resp);
        check_val("i_rdata", o_irdata, l2_rdata);
        check_val("d_rdata", o_drdata, l2_rdata);
        if (o_iresp) i_resp_cnt++;
        if (o_dresp) d_resp_cnt++;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        m_owner = M_IDLE; m_last = 1'b1;
        rand_req = 1'b0; keep_busy = 1'b0; ab_data = 1'b0; fixed_lat = -1;
        grants.delete();
        i_resp_cnt = 0; d_resp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_mem_read",  o_rd, 1'b0);
            check_val("rst_mem_write", o_wr, 1'b0);
            check_val("rst_mem_addr",  o_addr, 32'h0);
            check_val("rst_i_resp",    o_iresp, 1'b0);
        end
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while (!(m_owner == M_IDLE && !i_read && !d_read && !d_write) && c < budget) begin
            step();
            c++;
        end
        check_val("idle_within_budget", c < budget, 1'b1);
    endtask

    task automatic tie_test(input bit prio);
        sel = prio;
        do_reset();
        keep_busy = 1'b1;
        i_read  = 1'b1; i_addr = 32'h0000_2000;
        d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = rand_line();
        while (grants.size() < 5) step();
        for (int k = 0; k < 4; k++)
            check_val($sformatf("tie_p%0d_grant%0d", prio, k), grants[k], prio ? 1'b1 : k[0]);
        keep_busy = 1'b0;
        run_until_idle(100);
    endtask

    initial begin
        // Reset then idle
        sel = 1'b0;
        do_reset();
        repeat (5) step();

        // Lone I read with fixed latency and 0xAB.. data
        do_reset();
        ab_data = 1'b1; fixed_lat = 5;
        i_read = 1'b1; i_addr = 32'h0000_1040;
        run_until_idle(50);
        check_val("lone_i_resp_cnt", i_resp_cnt, 1);
        check_val("lone_d_resp_cnt", d_resp_cnt, 0);
        check_val("lone_grant_is_i", grants.size() == 1 && grants[0] == 1'b0, 1'b1);

        // Ties held: round-robin, then D priority
        tie_test(1'b0);
        tie_test(1'b1);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            rand_req = 1'b1;
            repeat (600) step();
            rand_req = 1'b0;
            run_until_idle(100);
        end

        // Async reset two cycles into a D write
        sel = 1'b0;
        do_reset();
        fixed_lat = 20;
        d_write = 1'b1; d_read = 1'b1; d_addr = 32'h0000_5000; d_wdata = rand_line();
        step();
        check_val("ar_granted_d", m_owner == M_D && o_wr == 1'b1 && o_rd == 1'b0, 1'b1);
        step();
        step();
        #1 rst = 1'b1;
        #1;
        check_val("ar_mem_write_drop", o_wr, 1'b0);
        check_val("ar_mem_addr_drop",  o_addr, 32'h0);
        check_val("ar_no_d_resp",      o_dresp, 1'b0);
        m_owner = M_IDLE; m_last = 1'b1; grants.delete();
        d_read = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_6040;
        @(negedge clk);
        check_val("ar_in_reset_write", o_wr, 1'b0);
        rst = 1'b0;
        fixed_lat = 2;
        step();
        check_val("ar_first_grant_i", grants.size() == 1 && grants[0] == 1'b0, 1'b1);
        run_until_idle(100);
        check_val("ar_d_resp_cnt", d_resp_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
